// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit generator: command codes, bit phases and
// the open-drain line values each command drives in each quarter-bit phase.
package i2c_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'd0;
    localparam logic [1:0] I2C_CMD_STOP  = 2'd1;
    localparam logic [1:0] I2C_CMD_WRITE = 2'd2;
    localparam logic [1:0] I2C_CMD_READ  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3
    } phase_t;

    // Packed {scl,sda} pairs, P0 in the top two bits down to P3 in the bottom two.
    localparam logic [7:0] START_LINES = 8'b11_11_10_00;
    localparam logic [7:0] STOP_LINES  = 8'b00_10_10_11;
    localparam logic [7:0] READ_LINES  = 8'b01_11_11_01;
    localparam logic [7:0] DATA_SCL    = 8'b00_10_10_00;

    function automatic logic [1:0] phase_lines(
        input logic [1:0] cmd,
        input logic       din,
        input logic [1:0] idx
    );
        logic [7:0] tbl;
        logic [1:0] pair;
        case (cmd)
            I2C_CMD_START: tbl = START_LINES;
            I2C_CMD_STOP:  tbl = STOP_LINES;
            I2C_CMD_WRITE: tbl = DATA_SCL | {4{1'b0, din}};
            default:       tbl = READ_LINES;
        endcase
        case (idx)
            2'd0:    pair = tbl[7:6];
            2'd1:    pair = tbl[5:4];
            2'd2:    pair = tbl[3:2];
            default: pair = tbl[1:0];
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/i2c_qtimer.sv
// Quarter-bit timer: loadable down-counter that freezes while SCL is being
// stretched and flags when the current quarter has run out.
module i2c_qtimer
    import i2c_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    input  logic         hold,
    output logic         zero
);

    logic [W-1:0] count;

    // Clear wins over load so an aborted command always parks the timer at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!hold && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/i2c_bit_gen.sv
// Bit-level I2C master line driver: runs one START/STOP/WRITE/READ command per
// handshake through four quarter-bit phases, with stretching and arbitration.
module i2c_bit_gen
    import i2c_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            cmd,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  din,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  cmd_done,
    output logic                  rx_bit,
    output logic                  al,
    output logic                  own,
    output logic                  scl_o,
    output logic                  sda_o,
    input  logic                  scl_i,
    input  logic                  sda_i,
    input  logic                  sta_det,
    input  logic                  sto_det
);

    phase_t                  state;
    phase_t                  state_nxt;
    logic [1:0]              cmd_q;
    logic                    din_q;
    logic [PRESCALE_W-1:0]   presc_q;
    logic [1:0]              lines_nxt;
    logic                    accept;
    logic                    stall;
    logic                    tick;
    logic                    lost;
    logic                    load;
    logic                    clear;
    logic                    zero;
    logic [PRESCALE_W-1:0]   load_val;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign stall     = scl_o & ~scl_i;
    assign tick      = (state != IDLE) && zero && !stall;
    assign load_val  = (state == IDLE) ? prescale : presc_q;

    i2c_qtimer #(
        .W (PRESCALE_W)
    ) u_qtimer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .load_val (load_val),
        .clear    (clear),
        .hold     (stall),
        .zero     (zero)
    );

    // Arbitration is only judged while SCL is nominally high (P1/P2).
    always_comb begin
        lost = 1'b0;
        if (state == P1 || state == P2) begin
            if (cmd_q == I2C_CMD_WRITE && din_q && scl_i && !sda_i) begin
                lost = 1'b1;
            end
            if (cmd_q != I2C_CMD_STOP && own && sto_det) begin
                lost = 1'b1;
            end
            if (cmd_q == I2C_CMD_START && sta_det) begin
                lost = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clear     = 1'b0;
        lines_nxt = {scl_o, sda_o};
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = P0;
                    load      = 1'b1;
                    lines_nxt = phase_lines(cmd, din, 2'd0);
                end
            end
            P0: begin
                if (tick) begin
                    state_nxt = P1;
                    load      = 1'b1;
                    lines_nxt = phase_lines(cmd_q, din_q, 2'd1);
                end
            end
            P1: begin
                if (tick) begin
                    state_nxt = P2;
                    load      = 1'b1;
                    lines_nxt = phase_lines(cmd_q, din_q, 2'd2);
                end
            end
            P2: begin
                if (tick) begin
                    state_nxt = P3;
                    load      = 1'b1;
                    lines_nxt = phase_lines(cmd_q, din_q, 2'd3);
                end
            end
            P3: begin
                if (tick) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                clear     = 1'b1;
                lines_nxt = 2'b11;
            end
        endcase
        // Losing the bus overrides any phase advance in the same cycle.
        if (lost) begin
            state_nxt = IDLE;
            load      = 1'b0;
            clear     = 1'b1;
            lines_nxt = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_o    <= 1'b1;
            sda_o    <= 1'b1;
            cmd_q    <= I2C_CMD_START;
            din_q    <= 1'b0;
            presc_q  <= '0;
            cmd_done <= 1'b0;
            al       <= 1'b0;
            own      <= 1'b0;
            rx_bit   <= 1'b0;
        end else begin
            {scl_o, sda_o} <= lines_nxt;
            cmd_done       <= (state == P3) && tick && !lost;
            al             <= lost;
            if (accept) begin
                cmd_q   <= cmd;
                din_q   <= din;
                presc_q <= prescale;
            end
            if (state == P2 && tick && !lost && cmd_q == I2C_CMD_READ) begin
                rx_bit <= sda_i;
            end
            if (lost) begin
                own <= 1'b0;
            end else if (state == P3 && tick) begin
                if (cmd_q == I2C_CMD_START) begin
                    own <= 1'b1;
                end else if (cmd_q == I2C_CMD_STOP) begin
                    own <= 1'b0;
                end
            end
        end
    end

endmodule
